mem_port_arbiter: RTL and testbench

//  Shares one single-ported synchronous RAM between the instruction-fetch (IF) port
//  and the load/store (MEM) port of the openmips core inside the min SOPC.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_grant.sv | 35 +++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM RAM port arbiter: FSM state codes, grant codes
// and the access-cycle counter width.
package mem_port_arbiter_pkg;

    // Transaction sequencing: IDLE -> ACCESS -> RESP -> IDLE
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    // Which requester owns the current transaction
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } arb_gnt_e;

    // Access counter width; bounds WAIT_CYCLES to 0..15
    localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between the fetch and load/store ports.
// Build option: MEM_ARB_RR_EN selects round-robin on contention; without it
// MEM always wins so a stalled load/store can never be starved by fetch.
module mem_arb_grant
    import mem_port_arbiter_pkg::*;
(
    input  logic     if_req_i,
    input  logic     mem_req_i,
    input  arb_gnt_e last_grant_i,
    output logic     grant_valid_o,
    output arb_gnt_e grant_o
);

    // Pick a winner; a lone requester is always granted
    always_comb begin
        grant_valid_o = if_req_i | mem_req_i;
        grant_o       = GNT_IF;
        if (if_req_i && mem_req_i) begin
`ifdef MEM_ARB_RR_EN
            grant_o = (last_grant_i == GNT_IF) ? GNT_MEM : GNT_IF;
`else
            grant_o = GNT_MEM;
`endif
        end else if (mem_req_i) begin
            grant_o = GNT_MEM;
        end
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority has no use for the history bit
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between the instruction-fetch and
// load/store ports. One transaction at a time: latch the winner's request,
// hold the RAM for WAIT_CYCLES+1 cycles, then pulse the winner's ack.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (last_grant reg).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    output logic                if_stall_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ack_o,
    output logic                mem_stall_o,
    output logic                ram_ce_o,
    output logic                ram_we_o,
    output logic [DATA_W/8-1:0] ram_sel_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [ARB_CNT_W-1:0] LAST_CNT = ARB_CNT_W'(WAIT_CYCLES);

    arb_state_e            state_q, state_d;
    logic [ARB_CNT_W-1:0]  cnt_q, cnt_d;
    arb_gnt_e              gnt_q, gnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;

    arb_gnt_e              last_grant;
    arb_gnt_e              grant;
    logic                  grant_valid;

    mem_arb_grant u_grant (
        .if_req_i      (if_req_i),
        .mem_req_i     (mem_req_i),
        .last_grant_i  (last_grant),
        .grant_valid_o (grant_valid),
        .grant_o       (grant)
    );

`ifdef MEM_ARB_RR_EN
    arb_gnt_e last_grant_q, last_grant_d;

    // Remember the most recent winner; only IDLE grants count
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == ARB_IDLE && grant_valid) begin
            last_grant_d = grant;
        end
    end

    // History register; starts at IF so the first contention goes to MEM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GNT_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = GNT_IF;
`endif

    // Next-state: arbitrate only in IDLE, count ACCESS cycles, capture read data on the last one
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_d = ARB_ACCESS;
                    cnt_d   = '0;
                    gnt_d   = grant;
                    if (grant == GNT_MEM) begin
                        addr_d  = mem_addr_i;
                        we_d    = mem_we_i;
                        sel_d   = mem_sel_i;
                        wdata_d = mem_wdata_i;
                    end else begin
                        addr_d  = if_addr_i;
                        we_d    = 1'b0;
                        sel_d   = '1;
                        wdata_d = '0;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ARB_RESP;
                    cnt_d   = '0;
                    if (!we_q) begin
                        if (gnt_q == GNT_MEM) begin
                            mem_rdata_d = ram_rdata_i;
                        end else begin
                            if_rdata_d = ram_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + ARB_CNT_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and latched request fields; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            gnt_q       <= GNT_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_ce_o    = (state_q == ARB_ACCESS);
    assign ram_we_o    = we_q & ram_ce_o;
    assign ram_sel_o   = sel_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;

    assign if_ack_o    = (state_q == ARB_RESP) && (gnt_q == GNT_IF);
    assign mem_ack_o   = (state_q == ARB_RESP) && (gnt_q == GNT_MEM);
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;

    // Stalls are forced low while reset is held so every output clears at once
    assign if_stall_o  = rst & if_req_i & ~if_ack_o;
    assign mem_stall_o = rst & mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (WAIT_CYCLES=1 and 0), each
// with its own RAM model, checked against a transaction-level reference.
module tb_mem_port_arbiter;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req    [NDUT];
    logic [31:0] if_addr   [NDUT];
    logic [31:0] if_rdata  [NDUT];
    logic        if_ack    [NDUT];
    logic        if_stall  [NDUT];
    logic        mem_req   [NDUT];
    logic        mem_we    [NDUT];
    logic [3:0]  mem_sel   [NDUT];
    logic [31:0] mem_addr  [NDUT];
    logic [31:0] mem_wdata [NDUT];
    logic [31:0] mem_rdata [NDUT];
    logic        mem_ack   [NDUT];
    logic        mem_stall [NDUT];
    logic        ram_ce    [NDUT];
    logic        ram_we    [NDUT];
    logic [3:0]  ram_sel   [NDUT];
    logic [31:0] ram_addr  [NDUT];
    logic [31:0] ram_wdata [NDUT];
    logic [31:0] ram_rdata [NDUT];

    int checks   = 0;
    int failures = 0;

    // Reference state: memory image per DUT and the rdata each port should show
    logic [31:0] ref_mem [int];
    logic [31:0] ex_if_rd  [NDUT];
    logic [31:0] ex_mem_rd [NDUT];
`ifdef MEM_ARB_RR_EN
    bit last_was_mem [NDUT];
`endif

    function automatic logic [31:0] init_word(int idx);
        return (idx == 4) ? 32'h3401_1100 : (32'hC0DE_0000 | 32'(idx));
    endfunction

    function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] wd, logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(int k, logic [31:0] a);
        int key;
        key = k * 256 + int'(a[9:2]);
        return ref_mem.exists(key) ? ref_mem[key] : init_word(int'(a[9:2]));
    endfunction

    task automatic ref_write(int k, logic [31:0] a, logic [3:0] sel, logic [31:0] wd);
        ref_mem[k * 256 + int'(a[9:2])] = merge_bytes(ref_read(k, a), wd, sel);
    endtask

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int WC = (gi == 0) ? 1 : 0;
        bit   [31:0] mem_arr [256];
        bit          wr_flag [256];
        logic [31:0] rd_q;
        logic [31:0] cur_word;
        logic [7:0]  idx;

        assign idx      = ram_addr[gi][9:2];
        assign cur_word = wr_flag[idx] ? mem_arr[idx] : init_word(int'(idx));

        // Synchronous RAM: writes on every enabled write cycle, read data lags ce by WC cycles
        always @(posedge clk) begin
            if (ram_ce[gi]) begin
                rd_q <= cur_word;
                if (ram_we[gi]) begin
                    mem_arr[idx] <= merge_bytes(cur_word, ram_wdata[gi], ram_sel[gi]);
                    wr_flag[idx] <= 1'b1;
                end
            end
        end

        if (WC == 0) begin : g_comb
            assign ram_rdata[gi] = cur_word;
        end else begin : g_reg
            assign ram_rdata[gi] = rd_q;
        end

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .if_req_i    (if_req[gi]),
            .if_addr_i   (if_addr[gi]),
            .if_rdata_o  (if_rdata[gi]),
            .if_ack_o    (if_ack[gi]),
            .if_stall_o  (if_stall[gi]),
            .mem_req_i   (mem_req[gi]),
            .mem_we_i    (mem_we[gi]),
            .mem_sel_i   (mem_sel[gi]),
            .mem_addr_i  (mem_addr[gi]),
            .mem_wdata_i (mem_wdata[gi]),
            .mem_rdata_o (mem_rdata[gi]),
            .mem_ack_o   (mem_ack[gi]),
            .mem_stall_o (mem_stall[gi]),
            .ram_ce_o    (ram_ce[gi]),
            .ram_we_o    (ram_we[gi]),
            .ram_sel_o   (ram_sel[gi]),
            .ram_addr_o  (ram_addr[gi]),
            .ram_wdata_o (ram_wdata[gi]),
            .ram_rdata_i (ram_rdata[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int k);
        chk("rst_if_ack",    32'(if_ack[k]),    32'h0);
        chk("rst_if_stall",  32'(if_stall[k]),  32'h0);
        chk("rst_if_rdata",  if_rdata[k],       32'h0);
        chk("rst_mem_ack",   32'(mem_ack[k]),   32'h0);
        chk("rst_mem_stall", 32'(mem_stall[k]), 32'h0);
        chk("rst_mem_rdata", mem_rdata[k],      32'h0);
        chk("rst_ram_ce",    32'(ram_ce[k]),    32'h0);
        chk("rst_ram_we",    32'(ram_we[k]),    32'h0);
        chk("rst_ram_sel",   32'(ram_sel[k]),   32'h0);
        chk("rst_ram_addr",  ram_addr[k],       32'h0);
        chk("rst_ram_wdata", ram_wdata[k],      32'h0);
    endtask

    // Issue one transaction (IF, MEM or both) from an idle DUT and check it cycle by cycle
    task automatic run_txn(input int k, input bit do_if, input bit do_mem, input bit we,
                           input logic [3:0] sel, input logic [31:0] a_if,
                           input logic [31:0] a_mem, input logic [31:0] wd);
        int  w, t_if, t_mem, t_end;
        bit  first_mem, in_if, in_mem;
        logic [31:0] rnd;
        w         = (k == 0) ? 1 : 0;
        first_mem = do_mem;
        if (do_if && do_mem) begin
`ifdef MEM_ARB_RR_EN
            first_mem       = !last_was_mem[k];
            last_was_mem[k] = !first_mem;
`else
            first_mem = 1'b1;
`endif
        end else begin
`ifdef MEM_ARB_RR_EN
            last_was_mem[k] = do_mem;
`endif
        end
        t_if  = 0;
        t_mem = 0;
        if (do_if && do_mem) begin
            if (first_mem) begin t_mem = w + 2; t_if = 2 * w + 5; end
            else           begin t_if  = w + 2; t_mem = 2 * w + 5; end
        end else if (do_if)  t_if  = w + 2;
        else if (do_mem)     t_mem = w + 2;
        t_end = ((t_if > t_mem) ? t_if : t_mem) + 1;

        if_req[k]    = do_if;
        if_addr[k]   = a_if;
        mem_req[k]   = do_mem;
        mem_we[k]    = we;
        mem_sel[k]   = sel;
        mem_addr[k]  = a_mem;
        mem_wdata[k] = wd;

        for (int n = 1; n <= t_end; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == t_if) ex_if_rd[k] = ref_read(k, a_if);
            if (n == t_mem) begin
                if (we) ref_write(k, a_mem, sel, wd);
                else    ex_mem_rd[k] = ref_read(k, a_mem);
            end
            in_if  = (t_if  != 0) && (n >= t_if  - w - 1) && (n < t_if);
            in_mem = (t_mem != 0) && (n >= t_mem - w - 1) && (n < t_mem);
            chk("ram_ce",    32'(ram_ce[k]),    32'(in_if | in_mem));
            chk("if_ack",    32'(if_ack[k]),    32'(n == t_if));
            chk("mem_ack",   32'(mem_ack[k]),   32'(n == t_mem));
            chk("if_stall",  32'(if_stall[k]),  32'(if_req[k] && n != t_if));
            chk("mem_stall", 32'(mem_stall[k]), 32'(mem_req[k] && n != t_mem));
            chk("if_rdata",  if_rdata[k],       ex_if_rd[k]);
            chk("mem_rdata", mem_rdata[k],      ex_mem_rd[k]);
            if (in_if) begin
                chk("if_ram_addr", ram_addr[k],     a_if);
                chk("if_ram_sel",  32'(ram_sel[k]), 32'hF);
                chk("if_ram_we",   32'(ram_we[k]),  32'h0);
            end
            if (in_mem) begin
                chk("mem_ram_addr", ram_addr[k],     a_mem);
                chk("mem_ram_sel",  32'(ram_sel[k]), 32'(sel));
                chk("mem_ram_we",   32'(ram_we[k]),  32'(we));
                if (we) chk("mem_ram_wdata", ram_wdata[k], wd);
            end
            if (n == t_if)  if_req[k]  = 1'b0;
            if (n == t_mem) mem_req[k] = 1'b0;
            // Once latched, the port inputs must no longer matter
            if (n == 1 && !(do_if && do_mem)) begin
                rnd          = $urandom();
                if_addr[k]   = rnd;
                mem_addr[k]  = ~rnd;
                mem_wdata[k] = $urandom();
                mem_sel[k]   = ~sel;
                mem_we[k]    = ~we;
            end
        end
        $display("txn dut=%0d if=%0b mem=%0b we=%0b sel=%h a_if=%h a_mem=%h wd=%h if_rdata=%h mem_rdata=%h",
                 k, do_if, do_mem, we, sel, a_if, a_mem, wd, if_rdata[k], mem_rdata[k]);
    endtask

    initial begin
        logic [31:0] a1, a2, d;
        int mode;
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; mem_req[k] = 1'b0; mem_we[k] = 1'b0;
            mem_sel[k] = '0; mem_addr[k] = '0; mem_wdata[k] = '0;
            ex_if_rd[k] = '0; ex_mem_rd[k] = '0;
`ifdef MEM_ARB_RR_EN
            last_was_mem[k] = 1'b0;
`endif
        end
        #1 rst = 1'b0;
        #2;
        for (int k = 0; k < NDUT; k++) chk_zero(k);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NDUT; k++) begin
            run_txn(k, 1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0);
            run_txn(k, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h0, 32'h100, 32'hDEAD_BEEF);
            run_txn(k, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h100, 32'h0);
            run_txn(k, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h10, 32'h0);
            run_txn(k, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h24, 32'h0);
            run_txn(k, 1'b1, 1'b1, 1'b1, 4'b1100, 32'h28, 32'h28, 32'h1234_5678);
        end

        for (int i = 0; i < 24; i++) begin
            a1 = $urandom(); a1[9:2] = 8'($urandom_range(0, 15)); a1[1:0] = 2'b00;
            a2 = $urandom(); a2[9:2] = 8'($urandom_range(0, 15)); a2[1:0] = 2'b00;
            d  = $urandom();
            mode = $urandom_range(0, 2);
            run_txn(i % 2, mode != 1, mode != 0, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), a1, a2, d);
        end

        // Reset in the middle of an IF read: no ack, everything clears immediately
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h30;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_ce", 32'(ram_ce[0]), 32'h1);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            ex_if_rd[k]  = '0;
            ex_mem_rd[k] = '0;
`ifdef MEM_ARB_RR_EN
            last_was_mem[k] = 1'b0;
`endif
        end
        chk_zero(0);
        chk("rst_dut1_addr", ram_addr[1], 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_held_ack", 32'(if_ack[0]), 32'h0);
        if_req[0] = 1'b0;
        #2 rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("post_rst_ack", 32'(if_ack[0]), 32'h0);
            chk("post_rst_ce",  32'(ram_ce[0]), 32'h0);
        end
        run_txn(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h30, 32'h0, 32'h0);
        run_txn(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h14, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
